lsu_mem_pipe: RTL and testbench
===============================

// Module: lsu_mem_pipe
// PURPOSE
// Parametrised load/store memory stage of the rv64IM pipeline, sitting between EX and WB.
// Replaces the zero-latency array stage: requests enter through a valid/ready handshake,
// take a configurable LATENCY, and return through a held valid/ready response.
// Adds alignment and range checking with a fault flag. One request outstanding at a time.
// PARAMETERS
// MEM_BYTES   1<<20          byte capacity of the data array (power of two)
// PMEM_BASE   64'h8000_0000  physical base address of the array
// LATENCY     2              cycles from load/store accept to resp_valid (>=1)
// PORTS
// clock        in   1   rising-edge clock
// reset        in   1   synchronous, active-high reset
// req_valid    in   1   request present
// req_ready    out  1   stage can accept a request
// load_i       in   1   request is a load
// store_i      in   1   request is a store (load_i and store_i never both set)
// funct3_i     in   3   [1:0] size 0=B 1=H 2=W 3=D; [2] unsigned load
// aluout_i     in   64  address for load/store, else ALU result
// sdata_i      in   64  store data, LSB-aligned
// wen_i        in   1   regfile write enable
// rd_i         in   5   destination register
// pc_i         in   64  instruction PC (debug)
// exit_i       in   1   exit marker (debug)
// resp_valid   out  1   response present
// resp_ready   in   1   WB accepts response
// wen_o        out  1   regfile write enable (forced 0 on fault)
// rd_o         out  5   destination register
// wdata_o      out  64  extended load data, or aluout_i; 0 on fault
// fault_o      out  1   misaligned or out-of-range access
// pc_o         out  64  captured pc_i
// exit_o       out  1   captured exit_i
// BEHAVIOUR
// - FSM states IDLE, BUSY, RESP. req_ready = (state==IDLE) && !reset.
// - Accept = req_valid && req_ready; all request fields captured at the accept edge.
// - IDLE->RESP on accepting a non-memory op or any faulting access (resp next cycle).
// - IDLE->BUSY on accepting a legal load/store; a down-counter is loaded with LATENCY-1.
//   BUSY->RESP when the counter reaches 0; LATENCY=1 goes straight to RESP.
// - RESP: resp_valid=1; all outputs held stable until resp_valid && resp_ready -> IDLE.
//   No new request is accepted in the handshake cycle (req_ready first rises in IDLE).
// - Fault if addr is not a multiple of 2^size, or addr < PMEM_BASE,
//   or addr+2^size > PMEM_BASE+MEM_BYTES (computed without 64-bit wrap).
//   A faulting store writes nothing; a faulting access gives wen_o=0, wdata_o=0, fault_o=1.
// - Store: bytes written little-endian at the accept edge. Only the 2^size bytes are
//   written; all other bytes are unchanged.
// - Load: array read on the BUSY->RESP edge (or the accept edge when LATENCY=1).
//   The read therefore sees every earlier store. Data is sign- or zero-extended per
//   funct3_i[2]. For D, funct3_i[2] is ignored.
// - Non-memory op: wdata_o = aluout_i, fault_o = 0.
// - Reset: state=IDLE, counter=0, resp_valid=0. wen_o, rd_o, wdata_o, fault_o, pc_o and
//   exit_o are 0. Array contents are not reset.
// - Reset mid-BUSY or in RESP drops the pending response. A store already accepted
//   remains committed.
// TESTING
// - SD 0x1122334455667788 @0x80000010, then LD @0x80000010 (LATENCY=2):
//   resp_valid 2 cycles after accept, wdata_o=0x1122334455667788.
// - Same memory, LB @0x80000010 -> wdata_o=0xFFFFFFFFFFFFFF88;
//   LBU -> 0x88; LHU @0x80000012 -> 0x5566.
// - LW @0x80000002 -> fault_o=1, wen_o=0, wdata_o=0. SW @0x7FFFFFFC -> fault_o=1 and
//   the array is unchanged (verify by LW at the in-range neighbour 0x80000000).
// - Hold resp_ready=0 for 5 cycles after resp_valid: outputs stable,
//   req_ready=0 throughout, and the next request is accepted only after the handshake.
// - Non-memory op with aluout_i=0x42, rd=5: one-cycle response, wdata_o=0x42, wen_o=1.
// - Assert reset during BUSY of a load: resp_valid stays 0, req_ready=1 the cycle after
//   reset deasserts. Repeat with LATENCY=1 and LATENCY=4 to check the counter bounds.

Source files
------------

// File: rtl/lsu_mem_pipe.sv
// Load/store memory stage between EX and WB: valid/ready request in, held valid/ready
// response out, configurable access latency, alignment/range fault detection.
module lsu_mem_pipe #(
    parameter int unsigned MEM_BYTES = 1 << 20,
    parameter logic [63:0] PMEM_BASE = 64'h8000_0000,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        load_i,
    input  logic        store_i,
    input  logic [2:0]  funct3_i,
    input  logic [63:0] aluout_i,
    input  logic [63:0] sdata_i,
    input  logic        wen_i,
    input  logic [4:0]  rd_i,
    input  logic [63:0] pc_i,
    input  logic        exit_i,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        wen_o,
    output logic [4:0]  rd_o,
    output logic [63:0] wdata_o,
    output logic        fault_o,
    output logic [63:0] pc_o,
    output logic        exit_o
);
    localparam int AW = $clog2(MEM_BYTES);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [64:0] PMEM_END = {1'b0, PMEM_BASE} + 65'(MEM_BYTES);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    logic [7:0]    mem [MEM_BYTES];
    state_t        state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] a_idx;
    logic [1:0]    a_size;
    logic          a_uns;
    logic          a_load;

    logic          accept, is_mem, misalign, range_bad, fault;
    logic [3:0]    nbytes;
    logic [2:0]    amask;
    logic [64:0]   req_end;
    logic [AW-1:0] req_idx;

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign is_mem    = load_i || store_i;
    assign nbytes    = 4'd1 << funct3_i[1:0];
    assign amask     = 3'(nbytes - 4'd1);
    assign misalign  = (aluout_i[2:0] & amask) != 3'd0;
    // End address is formed in 65 bits so an access near 2^64 cannot wrap into range.
    assign req_end   = {1'b0, aluout_i} + 65'(nbytes);
    assign range_bad = (aluout_i < PMEM_BASE) || (req_end > PMEM_END);
    assign fault     = is_mem && (misalign || range_bad);
    assign req_idx   = AW'(aluout_i - PMEM_BASE);

    function automatic logic [63:0] load_ext(input logic [AW-1:0] idx,
                                             input logic [1:0] size, input logic uns);
        logic [63:0] raw;
        for (int b = 0; b < 8; b++) raw[8*b +: 8] = mem[idx + AW'(b)];
        case (size)
            2'd0:    return uns ? {56'd0, raw[7:0]}  : {{56{raw[7]}}, raw[7:0]};
            2'd1:    return uns ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            2'd2:    return uns ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: return raw;
        endcase
    endfunction

    // Stores commit at the accept edge, so any later load already sees them.
    always_ff @(posedge clock) begin
        if (accept && store_i && !fault) begin
            for (int b = 0; b < 8; b++) begin
                if (4'(b) < nbytes) mem[req_idx + AW'(b)] <= sdata_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            wen_o      <= 1'b0;
            rd_o       <= '0;
            wdata_o    <= '0;
            fault_o    <= 1'b0;
            pc_o       <= '0;
            exit_o     <= 1'b0;
            a_idx      <= '0;
            a_size     <= '0;
            a_uns      <= 1'b0;
            a_load     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    rd_o   <= rd_i;
                    pc_o   <= pc_i;
                    exit_o <= exit_i;
                    a_idx  <= req_idx;
                    a_size <= funct3_i[1:0];
                    a_uns  <= funct3_i[2];
                    a_load <= load_i;
                    if (fault) begin
                        wen_o      <= 1'b0;
                        wdata_o    <= '0;
                        fault_o    <= 1'b1;
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end else begin
                        fault_o <= 1'b0;
                        wen_o   <= wen_i;
                        if (!is_mem) begin
                            wdata_o    <= aluout_i;
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else if (LATENCY == 1) begin
                            wdata_o    <= load_i ? load_ext(req_idx, funct3_i[1:0], funct3_i[2]) : '0;
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            wdata_o <= '0;
                            cnt     <= CW'(LATENCY - 1);
                            state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt <= CW'(1)) begin
                        cnt        <= '0;
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        if (a_load) wdata_o <= load_ext(a_idx, a_size, a_uns);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: if (resp_ready) begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_pipe.sv
// Randomized and directed bench for lsu_mem_pipe at LATENCY 2, 1 and 4, checked
// against a byte-map memory model with fault/extension rules computed arithmetically.
module tb_lsu_mem_pipe;
    localparam logic [63:0] BASE = 64'h8000_0000;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    logic        req_valid[3], req_ready[3], load_i[3], store_i[3], wen_i[3], exit_i[3];
    logic        resp_valid[3], resp_ready[3], wen_o[3], fault_o[3], exit_o[3];
    logic [2:0]  funct3_i[3];
    logic [63:0] aluout_i[3], sdata_i[3], pc_i[3], wdata_o[3], pc_o[3];
    logic [4:0]  rd_i[3], rd_o[3];

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            lsu_mem_pipe #(
                .MEM_BYTES(g == 0 ? 32'd1048576 : 32'd4096),
                .PMEM_BASE(BASE),
                .LATENCY  (g == 0 ? 2 : (g == 1 ? 1 : 4))
            ) u_dut (
                .clock(clock), .reset(reset),
                .req_valid(req_valid[g]), .req_ready(req_ready[g]),
                .load_i(load_i[g]), .store_i(store_i[g]), .funct3_i(funct3_i[g]),
                .aluout_i(aluout_i[g]), .sdata_i(sdata_i[g]), .wen_i(wen_i[g]),
                .rd_i(rd_i[g]), .pc_i(pc_i[g]), .exit_i(exit_i[g]),
                .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
                .wen_o(wen_o[g]), .rd_o(rd_o[g]), .wdata_o(wdata_o[g]),
                .fault_o(fault_o[g]), .pc_o(pc_o[g]), .exit_o(exit_o[g])
            );
        end
    endgenerate

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Reference memory: one byte map, keyed by DUT number in the upper bits.
    byte unsigned mm[longint];

    function automatic int lat_of(input int d);
        return d == 0 ? 2 : (d == 1 ? 1 : 4);
    endfunction

    function automatic longint unsigned mem_of(input int d);
        return d == 0 ? 64'd1048576 : 64'd4096;
    endfunction

    function automatic longint key(input int d, input logic [63:0] a);
        return longint'(a) + (longint'(d) << 48);
    endfunction

    function automatic bit m_fault(input int d, input logic [2:0] f3, input logic [63:0] a);
        longint unsigned nb = 64'd1 << f3[1:0];
        if (a % nb != 0) return 1'b1;
        if (a < BASE) return 1'b1;
        if (a - BASE + nb > mem_of(d)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] m_load(input int d, input logic [2:0] f3, input logic [63:0] a);
        logic [63:0] v = 64'd0;
        int nb = 1 << f3[1:0];
        for (int i = 0; i < nb; i++)
            if (mm.exists(key(d, a + 64'(i)))) v = v | (64'(mm[key(d, a + 64'(i))]) << (8 * i));
        if (nb < 8 && !f3[2] && v[8*nb-1]) v = v | (~64'd0 << (8 * nb));
        return v;
    endfunction

    task automatic m_store(input int d, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] sd);
        int nb = 1 << f3[1:0];
        for (int i = 0; i < nb; i++) mm[key(d, a + 64'(i))] = 8'(sd >> (8 * i));
    endtask

    task automatic drive(input int d, input bit ld, input bit st, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] sd, input bit wen,
                         input logic [4:0] rd, input logic [63:0] pc, input bit ex);
        req_valid[d] = 1'b1; load_i[d] = ld; store_i[d] = st; funct3_i[d] = f3;
        aluout_i[d] = a; sdata_i[d] = sd; wen_i[d] = wen; rd_i[d] = rd; pc_i[d] = pc; exit_i[d] = ex;
        @(posedge clock); #1;
        req_valid[d] = 1'b0; load_i[d] = 1'b0; store_i[d] = 1'b0;
    endtask

    // One full transaction: request, latency check, hold check, handshake.
    task automatic xact(input int d, input bit ld, input bit st, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] sd, input bit wen,
                        input logic [4:0] rd, input int hold, input string tag);
        bit          flt    = (ld || st) && m_fault(d, f3, a);
        int          e_lat  = ((ld || st) && !flt) ? lat_of(d) : 1;
        logic [63:0] e_wd   = flt ? 64'd0 : (ld ? m_load(d, f3, a) : a);
        bit          chk_wd = !(st && !flt);
        logic [63:0] pc     = {$urandom, $urandom};
        bit          ex     = 1'($urandom_range(0, 1));
        logic [63:0] s_wd, s_misc, e_misc;
        int cyc;
        if (st && !flt) m_store(d, f3, a, sd);
        chk({tag, ".req_ready"}, 64'(req_ready[d]), 64'd1);
        drive(d, ld, st, f3, a, sd, wen, rd, pc, ex);
        cyc = 1;
        while (!resp_valid[d] && cyc < 40) begin
            @(posedge clock); #1;
            cyc++;
        end
        chk({tag, ".latency"}, 64'(cyc), 64'(e_lat));
        chk({tag, ".busy_ready"}, 64'(req_ready[d]), 64'd0);
        e_misc = {56'd0, (wen && !flt), flt, ex, rd};
        s_misc = {56'd0, wen_o[d], fault_o[d], exit_o[d], rd_o[d]};
        s_wd   = wdata_o[d];
        chk({tag, ".misc"}, s_misc, e_misc);
        chk({tag, ".pc"}, pc_o[d], pc);
        if (chk_wd) chk({tag, ".wdata"}, s_wd, e_wd);
        for (int h = 0; h < hold; h++) begin
            @(posedge clock); #1;
            chk({tag, ".hold_valid"}, 64'(resp_valid[d]), 64'd1);
            chk({tag, ".hold_ready"}, 64'(req_ready[d]), 64'd0);
            chk({tag, ".hold_wdata"}, wdata_o[d], s_wd);
            chk({tag, ".hold_misc"}, {56'd0, wen_o[d], fault_o[d], exit_o[d], rd_o[d]}, s_misc);
        end
        resp_ready[d] = 1'b1;
        @(posedge clock); #1;
        resp_ready[d] = 1'b0;
        chk({tag, ".done_valid"}, 64'(resp_valid[d]), 64'd0);
    endtask

    // Reset while a request is in flight; any accepted store stays committed.
    task automatic rst_mid(input int d, input bit st, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] sd, input string tag);
        if (st && !m_fault(d, f3, a)) m_store(d, f3, a, sd);
        drive(d, !st, st, f3, a, sd, 1'b1, 5'd3, 64'h100, 1'b0);
        if (lat_of(d) > 2) begin
            @(posedge clock); #1;
            chk({tag, ".busy_valid"}, 64'(resp_valid[d]), 64'd0);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        chk({tag, ".rst_valid"}, 64'(resp_valid[d]), 64'd0);
        chk({tag, ".rst_ready"}, 64'(req_ready[d]), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk({tag, ".post_valid"}, 64'(resp_valid[d]), 64'd0);
        chk({tag, ".post_ready"}, 64'(req_ready[d]), 64'd1);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 0; load_i[d] = 0; store_i[d] = 0; funct3_i[d] = 0; aluout_i[d] = 0;
            sdata_i[d] = 0; wen_i[d] = 0; rd_i[d] = 0; pc_i[d] = 0; exit_i[d] = 0; resp_ready[d] = 0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("reset.req_ready", 64'(req_ready[d]), 64'd0);
            chk("reset.resp_valid", 64'(resp_valid[d]), 64'd0);
            chk("reset.wdata", wdata_o[d], 64'd0);
            chk("reset.pc", pc_o[d], 64'd0);
            chk("reset.misc", {56'd0, wen_o[d], fault_o[d], exit_o[d], rd_o[d]}, 64'd0);
        end
        reset = 1'b0;
        #1;

        // Fill a window so every random load reads known bytes.
        for (int i = 0; i < 34; i++)
            xact(0, 0, 1, 3'd3, BASE + 64'(8 * i), {$urandom, $urandom}, 0, 0, 0, "init");

        xact(0, 0, 1, 3'd3, BASE + 64'h10, 64'h1122334455667788, 0, 0, 0, "sd");
        xact(0, 1, 0, 3'd3, BASE + 64'h10, 64'd0, 1, 5'd1, 0, "ld");
        xact(0, 1, 0, 3'd0, BASE + 64'h10, 64'd0, 1, 5'd2, 0, "lb");
        xact(0, 1, 0, 3'd4, BASE + 64'h10, 64'd0, 1, 5'd3, 0, "lbu");
        xact(0, 1, 0, 3'd5, BASE + 64'h12, 64'd0, 1, 5'd4, 0, "lhu");
        xact(0, 1, 0, 3'd2, BASE + 64'h2, 64'd0, 1, 5'd5, 0, "lw_mis");
        xact(0, 0, 1, 3'd3, BASE, 64'hA5A5_5A5A_0F0F_F0F0, 0, 0, 0, "sd_base");
        xact(0, 0, 1, 3'd2, BASE - 64'd4, 64'hDEAD_BEEF, 0, 0, 0, "sw_low");
        xact(0, 1, 0, 3'd2, BASE, 64'd0, 1, 5'd6, 0, "lw_base");
        xact(0, 1, 0, 3'd3, BASE + 64'h10, 64'd0, 1, 5'd7, 5, "ld_hold");
        xact(0, 0, 0, 3'd0, 64'h42, 64'd0, 1, 5'd5, 0, "nonmem");

        for (int n = 0; n < 200; n++) begin
            int          op = $urandom_range(0, 6);
            logic [2:0]  f3 = 3'($urandom_range(0, 7));
            int          nb = 1 << f3[1:0];
            logic [63:0] off = 64'($urandom_range(0, 255));
            logic [63:0] a;
            if ($urandom_range(0, 3) != 0) off = off & ~64'(nb - 1);
            a = BASE + off;
            if ($urandom_range(0, 15) == 0) a = BASE - 64'($urandom_range(1, 16));
            xact(0, op < 3, op >= 3 && op < 6, f3, a, {$urandom, $urandom},
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom_range(0, 3), "rand");
        end
        rst_mid(0, 0, 3'd3, BASE + 64'h10, 64'd0, "rst_l2");

        xact(1, 0, 1, 3'd3, BASE + 64'd4088, 64'h0102_0304_0506_0708, 0, 0, 0, "l1_sd_top");
        xact(1, 1, 0, 3'd3, BASE + 64'd4088, 64'd0, 1, 5'd8, 0, "l1_ld_top");
        xact(1, 0, 1, 3'd1, BASE + 64'd4094, 64'hBEEF, 0, 0, 0, "l1_sh_last");
        xact(1, 0, 1, 3'd2, BASE + 64'd4092, 64'hCAFE_F00D, 0, 0, 0, "l1_sw_last");
        xact(1, 0, 1, 3'd2, BASE + 64'd4096, 64'h1234_5678, 0, 0, 0, "l1_sw_over");
        xact(1, 0, 1, 3'd3, BASE + 64'd4090, 64'h1, 0, 0, 0, "l1_sd_mis");
        xact(1, 1, 0, 3'd1, BASE + 64'd4094, 64'd0, 1, 5'd9, 2, "l1_lh_last");
        xact(1, 1, 0, 3'd3, BASE + 64'd4088, 64'd0, 1, 5'd10, 0, "l1_ld_back");
        rst_mid(1, 0, 3'd3, BASE + 64'd4088, 64'd0, "rst_l1");

        xact(2, 0, 1, 3'd3, BASE, 64'hFEDC_BA98_7654_3210, 0, 0, 0, "l4_sd");
        xact(2, 1, 0, 3'd6, BASE + 64'd4, 64'd0, 1, 5'd11, 0, "l4_lwu");
        xact(2, 1, 0, 3'd2, BASE + 64'd4, 64'd0, 1, 5'd12, 3, "l4_lw");
        rst_mid(2, 1, 3'd3, BASE + 64'd8, 64'h0BAD_C0DE_1357_9BDF, "rst_l4_st");
        xact(2, 1, 0, 3'd3, BASE + 64'd8, 64'd0, 1, 5'd13, 0, "l4_ld_commit");
        rst_mid(2, 0, 3'd3, BASE, 64'd0, "rst_l4_ld");
        xact(2, 1, 0, 3'd1, BASE + 64'd2, 64'd0, 1, 5'd14, 0, "l4_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
